// File: rtl/pipe_stage_reg_if.sv
// Valid/ready/data handshake bundle for one side of an elastic pipeline stage.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: one or two entries, flush to a bubble
// payload, and a saturating back-pressure counter.
module pipe_stage_reg #(
    parameter int          DATA_W = 32,
    parameter logic [31:0] BUBBLE = 32'h0000_0013,
    parameter int          SKID   = 1,
    parameter int          CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    pipe_stage_reg_if.slave  in_if,
    pipe_stage_reg_if.master out_if,
    output logic [1:0]       count,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [DATA_W-1:0] BUBBLE_D = DATA_W'(BUBBLE);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] main_q;
    logic              out_valid;
    logic              in_ready;
    logic              ix;
    logic              ox;

    assign out_valid    = (state != EMPTY);
    assign ix           = in_if.valid & in_ready;
    assign ox           = out_valid & out_if.ready;
    assign in_if.ready  = in_ready;
    assign out_if.valid = out_valid;
    assign out_if.data  = main_q;
    assign count        = state;

    generate
        if (SKID != 0) begin : g_skid
            logic [DATA_W-1:0] skid_q;
            logic              rdy_q;

            assign in_ready = rdy_q;

            // rdy_q is precomputed as "next state is not TWO" so in_ready
            // never depends combinationally on out_ready.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    state  <= EMPTY;
                    main_q <= BUBBLE_D;
                    skid_q <= BUBBLE_D;
                    rdy_q  <= 1'b1;
                end else if (flush) begin
                    state  <= EMPTY;
                    main_q <= BUBBLE_D;
                    skid_q <= BUBBLE_D;
                    rdy_q  <= 1'b1;
                end else begin
                    case (state)
                        EMPTY: begin
                            if (ix) begin
                                main_q <= in_if.data;
                                state  <= ONE;
                            end
                        end
                        ONE: begin
                            if (ix && ox) begin
                                main_q <= in_if.data;
                            end else if (ix) begin
                                skid_q <= in_if.data;
                                state  <= TWO;
                                rdy_q  <= 1'b0;
                            end else if (ox) begin
                                main_q <= BUBBLE_D;
                                state  <= EMPTY;
                            end
                        end
                        TWO: begin
                            if (ox) begin
                                main_q <= skid_q;
                                skid_q <= BUBBLE_D;
                                state  <= ONE;
                                rdy_q  <= 1'b1;
                            end
                        end
                        default: begin
                            state  <= EMPTY;
                            main_q <= BUBBLE_D;
                            skid_q <= BUBBLE_D;
                            rdy_q  <= 1'b1;
                        end
                    endcase
                end
            end
        end else begin : g_noskid
            assign in_ready = ~out_valid | out_if.ready;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    state  <= EMPTY;
                    main_q <= BUBBLE_D;
                end else if (flush) begin
                    state  <= EMPTY;
                    main_q <= BUBBLE_D;
                end else if (ix) begin
                    main_q <= in_if.data;
                    state  <= ONE;
                end else if (ox) begin
                    main_q <= BUBBLE_D;
                    state  <= EMPTY;
                end
            end
        end
    endgenerate

    // Survives flush on purpose so stalls around a redirect stay visible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (out_valid && !out_if.ready && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid, narrow-counter and no-skid variants.
module tb_pipe_stage_reg;

    localparam logic [31:0] BUB = 32'h0000_0013;

    logic clk;
    logic reset;
    logic flush;

    logic [1:0]  a_count, b_count, c_count;
    logic [15:0] a_stall, c_stall;
    logic [3:0]  b_stall;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] sb_q[$];

    pipe_stage_reg_if #(.DATA_W(32)) a_in ();
    pipe_stage_reg_if #(.DATA_W(32)) a_out ();
    pipe_stage_reg_if #(.DATA_W(32)) b_in ();
    pipe_stage_reg_if #(.DATA_W(32)) b_out ();
    pipe_stage_reg_if #(.DATA_W(32)) c_in ();
    pipe_stage_reg_if #(.DATA_W(32)) c_out ();

    pipe_stage_reg #(.DATA_W(32), .BUBBLE(BUB), .SKID(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .flush(flush),
        .in_if(a_in.slave), .out_if(a_out.master),
        .count(a_count), .stall_cycles(a_stall)
    );

    pipe_stage_reg #(.DATA_W(32), .BUBBLE(BUB), .SKID(1), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .flush(flush),
        .in_if(b_in.slave), .out_if(b_out.master),
        .count(b_count), .stall_cycles(b_stall)
    );

    pipe_stage_reg #(.DATA_W(32), .BUBBLE(BUB), .SKID(0), .CNT_W(16)) dut_c (
        .clk(clk), .reset(reset), .flush(flush),
        .in_if(c_in.slave), .out_if(c_out.master),
        .count(c_count), .stall_cycles(c_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard on the skid instance: occupancy, bubble, ready invariant, FIFO order.
    always @(negedge clk) begin
        if (!reset) begin
            sb_q.delete();
        end else begin
            chk("sb_count", 32'(a_count), 32'(sb_q.size()));
            if (!a_in.ready) chk("inv_ready_two", 32'(a_count), 32'd2);
            if (!a_out.valid) chk("sb_bubble", a_out.data, BUB);
            if (a_out.valid && a_out.ready) begin
                if (sb_q.size() == 0) chk("sb_underflow", 32'(sb_q.size()), 32'd1);
                else chk("sb_order", a_out.data, sb_q.pop_front());
            end
            if (flush) sb_q.delete();
            else if (a_in.valid && a_in.ready) sb_q.push_back(a_in.data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        a_in.valid = 1'b0; a_in.data = '0; a_out.ready = 1'b0;
        b_in.valid = 1'b0; b_in.data = '0; b_out.ready = 1'b0;
        c_in.valid = 1'b0; c_in.data = '0; c_out.ready = 1'b0;

        // reset with random inputs, checked before the first edge
        #2;
        reset = 1'b0;
        a_in.valid  = 1'($urandom_range(0, 1));
        a_in.data   = $urandom;
        a_out.ready = 1'($urandom_range(0, 1));
        c_in.valid  = 1'($urandom_range(0, 1));
        c_in.data   = $urandom;
        #1;
        chk("rst_valid", 32'(a_out.valid), 32'd0);
        chk("rst_data", a_out.data, BUB);
        chk("rst_count", 32'(a_count), 32'd0);
        chk("rst_ready", 32'(a_in.ready), 32'd1);
        chk("rst_stall", 32'(a_stall), 32'd0);
        chk("rst_c_data", c_out.data, BUB);
        @(posedge clk);
        #1;
        a_in.valid = 1'b0; a_out.ready = 1'b0; c_in.valid = 1'b0;
        reset = 1'b1;
        step();

        // streaming 1..100 with out_ready held high
        a_out.ready = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            a_in.valid = 1'b1;
            a_in.data  = 32'(i);
            step();
            chk("stream_data", a_out.data, 32'(i));
            chk("stream_count", 32'(a_count), 32'd1);
            chk("stream_ready", 32'(a_in.ready), 32'd1);
        end
        a_in.valid = 1'b0;
        step();
        chk("stream_drain", 32'(a_out.valid), 32'd0);
        chk("stream_stall", 32'(a_stall), 32'd0);

        // back-pressure: A, B, then five stalled cycles in total
        a_out.ready = 1'b0;
        a_in.valid = 1'b1; a_in.data = 32'hA;
        step();
        chk("bp_first", a_out.data, 32'hA);
        a_in.data = 32'hB;
        step();
        a_in.valid = 1'b0;
        repeat (4) step();
        chk("bp_count", 32'(a_count), 32'd2);
        chk("bp_ready", 32'(a_in.ready), 32'd0);
        chk("bp_data", a_out.data, 32'hA);
        chk("bp_stall", 32'(a_stall), 32'd5);
        a_out.ready = 1'b1;
        step();
        chk("bp_rel_data", a_out.data, 32'hB);
        chk("bp_rel_count", 32'(a_count), 32'd1);
        chk("bp_rel_ready", 32'(a_in.ready), 32'd1);
        step();
        chk("bp_empty_count", 32'(a_count), 32'd0);
        chk("bp_empty_data", a_out.data, BUB);

        // flush while full, with a coincident 0xC offered
        a_out.ready = 1'b0;
        a_in.valid = 1'b1; a_in.data = 32'hA;
        step();
        a_in.data = 32'hB;
        step();
        chk("fl_pre_count", 32'(a_count), 32'd2);
        flush = 1'b1;
        a_in.data = 32'hC;
        step();
        flush = 1'b0;
        a_in.valid = 1'b0;
        chk("fl_valid", 32'(a_out.valid), 32'd0);
        chk("fl_data", a_out.data, BUB);
        chk("fl_count", 32'(a_count), 32'd0);
        chk("fl_ready", 32'(a_in.ready), 32'd1);
        chk("fl_stall_kept", 32'(a_stall), 32'd7);
        a_out.ready = 1'b1;
        repeat (3) begin
            step();
            chk("fl_no_c", 32'(a_out.valid), 32'd0);
        end

        // asynchronous reset while two payloads are held
        a_out.ready = 1'b0;
        a_in.valid = 1'b1; a_in.data = 32'hD;
        step();
        a_in.data = 32'hE;
        step();
        a_in.valid = 1'b0;
        chk("mr_pre_count", 32'(a_count), 32'd2);
        chk("mr_pre_stall", 32'(a_stall), 32'd8);
        #2;
        reset = 1'b0;
        #1;
        chk("mr_count", 32'(a_count), 32'd0);
        chk("mr_valid", 32'(a_out.valid), 32'd0);
        chk("mr_data", a_out.data, BUB);
        chk("mr_ready", 32'(a_in.ready), 32'd1);
        chk("mr_stall", 32'(a_stall), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step();

        // 4-bit counter saturation
        b_out.ready = 1'b0;
        b_in.valid = 1'b1; b_in.data = 32'h55;
        step();
        b_in.valid = 1'b0;
        repeat (14) step();
        chk("sat_14", 32'(b_stall), 32'd14);
        repeat (6) step();
        chk("sat_20", 32'(b_stall), 32'd15);
        step();
        chk("sat_hold", 32'(b_stall), 32'd15);
        chk("sat_data", b_out.data, 32'h55);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("sat_flush_stall", 32'(b_stall), 32'd15);
        chk("sat_flush_count", 32'(b_count), 32'd0);

        // single-entry variant with combinational in_ready
        c_out.ready = 1'b1;
        c_in.valid = 1'b1; c_in.data = 32'h7;
        step();
        c_in.valid = 1'b0;
        chk("ns_load_data", c_out.data, 32'h7);
        chk("ns_load_count", 32'(c_count), 32'd1);
        c_out.ready = 1'b0;
        #1;
        chk("ns_ready_low", 32'(c_in.ready), 32'd0);
        c_in.valid = 1'b1; c_in.data = 32'h9;
        step();
        chk("ns_blocked", c_out.data, 32'h7);
        c_out.ready = 1'b1;
        c_in.data = 32'h5;
        #1;
        chk("ns_ready_high", 32'(c_in.ready), 32'd1);
        step();
        chk("ns_pass_data", c_out.data, 32'h5);
        chk("ns_pass_count", 32'(c_count), 32'd1);
        c_in.valid = 1'b0;
        step();
        chk("ns_drain_valid", 32'(c_out.valid), 32'd0);
        chk("ns_drain_data", c_out.data, BUB);
        chk("ns_drain_count", 32'(c_count), 32'd0);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generalised, elastic pipeline stage register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one opaque payload bus of DATA_W bits under a valid/ready handshake, with an optional skid entry so that in_ready is fully registered.
- Synchronous flush drops every held entry and drives a parametrised bubble payload, which is a NOP for instruction-carrying stages.
- Keeps a saturating back-pressure counter for performance debug.

Parameters:
DATA_W, 32, payload width in bits; legal range is 1 or more.
BUBBLE, 32'h0000_0013, payload value held when an entry is empty, after flush and after reset; truncated or zero-extended to DATA_W.
SKID, 1, 1 selects a two-entry skid buffer with registered in_ready; 0 selects a single entry with combinational in_ready.
CNT_W, 16, width of the stall_cycles counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
flush  in  1  synchronous flush; highest priority after reset.
in_valid  in  1  upstream payload valid.
in_ready  out  1  stage can accept a payload this cycle.
in_data  in  DATA_W  upstream payload.
out_valid  out  1  head entry valid.
out_ready  in  1  downstream accepts the head entry this cycle.
out_data  out  DATA_W  head entry payload; equals BUBBLE when out_valid=0.
count  out  2  number of occupied entries: 0, 1 or 2.
stall_cycles  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Handshake definitions:
  - Input transfer (IX) = in_valid & in_ready.
  - Output transfer (OX) = out_valid & out_ready.
  - in_data is sampled only on IX.
  - out_data is stable while out_valid=1 and out_ready=0.
- Storage:
  - main register: drives out_data.
  - skid register: present only when SKID=1.
  - State is the occupancy: EMPTY, ONE or TWO; TWO exists only when SKID=1.
- SKID=1 transitions:
  - in_ready = (state != TWO), registered.
  - EMPTY: IX -> ONE, main<=in_data.
  - ONE: IX&OX -> ONE, main<=in_data. IX only -> TWO, skid<=in_data. OX only -> EMPTY, main<=BUBBLE.
  - TWO: IX is impossible. OX -> ONE, main<=skid, skid<=BUBBLE.
  - Latency EMPTY->out_valid is 1 cycle. Zero-bubble throughput of 1 payload per cycle is held under continuous out_ready=1.
- SKID=0 transitions:
  - in_ready = !out_valid | out_ready, combinational.
  - IX -> main<=in_data, state ONE.
  - OX without IX -> EMPTY, main<=BUBBLE.
  - count never exceeds 1.
- Outputs:
  - out_valid = (state != EMPTY).
  - count encodes the state as 0, 1 or 2.
- flush=1 at an edge:
  - state<=EMPTY, main<=BUBBLE, skid<=BUBBLE.
  - A coincident IX is consumed and discarded.
  - A coincident OX counts as delivered downstream.
  - in_ready is 1 in the cycle after a flush.
- reset low, asynchronous:
  - Immediately forces the same state as flush, plus stall_cycles<=0 and in_ready<=1 (SKID=1).
  - Reset asserted mid-transfer discards all held payloads.
  - Deassertion is sampled synchronously by the surrounding design; the block itself takes no further action.
- stall_cycles:
  - Increments by 1 each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Not cleared by flush; only reset clears it.
- Simultaneous events: reset > flush > handshake updates.
- Invariants (assert in bench):
  - The skid register is never occupied while main is empty.
  - in_ready=0 implies state TWO (SKID=1).
  - No payload is duplicated or reordered: payloads leave in FIFO order.

Test Plan:
- Reset: drive reset=0 with random inputs -> out_valid=0, out_data=32'h00000013, count=0, in_ready=1, stall_cycles=0, all asynchronously before the next edge.
- Streaming, SKID=1: in_valid=1 with data 1,2,3,...,100 and out_ready=1 every cycle -> out_data=1 appears 1 cycle after the first IX, then one payload per cycle in order; count stays 1; in_ready never drops.
- Back-pressure: load 0xA, 0xB, then hold out_ready=0 for 5 cycles -> count=2, in_ready=0, out_data=0xA stable, stall_cycles=5. Release out_ready -> 0xA then 0xB delivered, count reaches 0.
- Flush: with count=2, assert flush together with in_valid=1 and in_data=0xC -> next cycle out_valid=0, out_data=BUBBLE, count=0; 0xC is never output.
- Saturation with CNT_W=4: hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cycles reads 15 and stays 15; a subsequent flush leaves it at 15.
- SKID=0 variant: set out_ready=0 with one entry held -> in_ready=0 combinationally in the same cycle. Set out_ready=1 and in_valid=1 with data 0x5 -> 0x5 is accepted in that cycle and appears at out_data on the next cycle.
